// File: rtl/mag_compare_serial.sv
// Serial magnitude comparator: compares two WIDTH-bit operands CHUNK bits per
// cycle, most significant chunk first, and stops as soon as a chunk differs.
// Signed compares are mapped onto the unsigned datapath by flipping the MSB
// of both operands when they are latched.
module mag_compare_serial #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             busy_q;
    logic             done_q;
    logic             gt_q;
    logic             eq_q;
    logic             lt_q;

    logic [WIDTH-1:0] flip_s;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [CHUNK-1:0] chunk_a_s;
    logic [CHUNK-1:0] chunk_b_s;

    // Operand conditioning for the latch and selection of the chunk under compare.
    always_comb begin
        flip_s    = {signed_mode, {(WIDTH-1){1'b0}}};
        a_d       = a ^ flip_s;
        b_d       = b ^ flip_s;
        chunk_a_s = a_q[idx_q*CHUNK +: CHUNK];
        chunk_b_s = b_q[idx_q*CHUNK +: CHUNK];
    end

    // Control FSM with registered status and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        idx_q   <= IW'(NCH - 1);
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (chunk_a_s != chunk_b_s) begin
                        // First differing chunk decides the result.
                        gt_q    <= (chunk_a_s > chunk_b_s);
                        lt_q    <= (chunk_a_s < chunk_b_s);
                        eq_q    <= 1'b0;
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (idx_q == '0) begin
                        gt_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        eq_q    <= 1'b1;
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_q - IW'(1);
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign eq   = eq_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_mag_compare_serial.sv
// Directed bench for mag_compare_serial: an 8-bit/2-bit instance for the
// latency, signed, back-to-back and reset scenarios, and a 2-bit/1-bit
// instance for an exhaustive sweep against a golden model.
module tb_mag_compare_serial;

    logic clk;
    logic rst_n;

    logic       start8, sm8, busy8, done8, gt8, eq8, lt8;
    logic [7:0] a8, b8;

    logic       start2, sm2, busy2, done2, gt2, eq2, lt2;
    logic [1:0] a2, b2;

    int n_checks;
    int n_fail;

    mag_compare_serial #(.WIDTH(8), .CHUNK(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .signed_mode(sm8), .busy(busy8), .done(done8),
        .gt(gt8), .eq(eq8), .lt(lt8)
    );

    mag_compare_serial #(.WIDTH(2), .CHUNK(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .signed_mode(sm2), .busy(busy2), .done(done2),
        .gt(gt2), .eq(eq2), .lt(lt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one compare on the 8-bit instance and wait for done.
    // lat = cycles from start edge to DONE edge; bcnt = cycles with busy=1.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                        output int lat, output int bcnt, output logic to);
        @(negedge clk);
        a8 = av; b8 = bv; sm8 = sm; start8 = 1'b1;
        lat = 0; bcnt = 0; to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (busy8) bcnt++;
            if (done8) begin
                lat = i;
                to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic chk_res8(input string name, input logic eg, input logic ee, input logic el,
                            input int lat, input int elat, input logic to);
        n_checks++;
        if (to !== 1'b0) begin
            n_fail++;
            $display("FAIL %s timeout: no done within bound, required done", name);
        end
        n_checks++;
        if ({gt8, eq8, lt8} !== {eg, ee, el}) begin
            n_fail++;
            $display("FAIL %s result: got gt/eq/lt=%b%b%b, required %b%b%b", name, gt8, eq8, lt8, eg, ee, el);
        end
        n_checks++;
        if (lat !== elat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d, required %0d", name, lat, elat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; sm8 = 1'b0;
        start2 = 1'b0; a2 = 2'd0;  b2 = 2'd0;  sm2 = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy8, done8, gt8, eq8, lt8} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset8: got busy/done/gt/eq/lt=%b%b%b%b%b, required 00000", busy8, done8, gt8, eq8, lt8);
        end
        n_checks++;
        if ({busy2, done2, gt2, eq2, lt2} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset2: got busy/done/gt/eq/lt=%b%b%b%b%b, required 00000", busy2, done2, gt2, eq2, lt2);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bcnt;
        logic to;
        run8(8'hA5, 8'h5A, 1'b0, lat, bcnt, to);
        chk_res8("a5_5a", 1'b1, 1'b0, 1'b0, lat, 1, to);
        n_checks++;
        if (bcnt !== 1) begin
            n_fail++;
            $display("FAIL a5_5a busy cycles: got %0d, required 1", bcnt);
        end
        n_checks++;
        if (busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_in_done: got %b, required 0", busy8);
        end
        run8(8'h3C, 8'h3C, 1'b0, lat, bcnt, to);
        chk_res8("3c_3c", 1'b0, 1'b1, 1'b0, lat, 4, to);
        n_checks++;
        if (bcnt !== 4) begin
            n_fail++;
            $display("FAIL 3c_3c busy cycles: got %0d, required 4", bcnt);
        end
        // done is a single-cycle pulse; results hold in IDLE.
        @(negedge clk);
        n_checks++;
        if ({done8, gt8, eq8, lt8} !== 4'b0010) begin
            n_fail++;
            $display("FAIL hold_after_done: got done/gt/eq/lt=%b%b%b%b, required 0010", done8, gt8, eq8, lt8);
        end
    endtask

    task automatic test_signed();
        int lat, bcnt;
        logic to;
        run8(8'h80, 8'h01, 1'b1, lat, bcnt, to);
        chk_res8("80_01_signed", 1'b0, 1'b0, 1'b1, lat, 1, to);
        run8(8'h80, 8'h01, 1'b0, lat, bcnt, to);
        chk_res8("80_01_unsigned", 1'b1, 1'b0, 1'b0, lat, 1, to);
    endtask

    task automatic test_back_to_back();
        int lat;
        logic to;
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h10; sm8 = 1'b0; start8 = 1'b1;
        lat = 0; to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            // Second cycle of RUN: pulse an ignored start with different operands.
            if (i == 1) begin
                a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            if (done8) begin
                lat = i;
                to  = 1'b0;
                break;
            end
        end
        chk_res8("b2b_first", 1'b1, 1'b0, 1'b0, lat, 4, to);
        // In the DONE cycle: request the next compare (0x00 vs 0xC0 -> lt, k=1).
        a8 = 8'h00; b8 = 8'hC0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n_checks++;
        if ({busy8, done8} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy/done=%b%b, required 10", busy8, done8);
        end
        n_checks++;
        if ({gt8, eq8, lt8} !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_hold_in_run: got gt/eq/lt=%b%b%b, required 100", gt8, eq8, lt8);
        end
        @(negedge clk);
        n_checks++;
        if ({done8, gt8, eq8, lt8} !== 4'b1001) begin
            n_fail++;
            $display("FAIL b2b_second: got done/gt/eq/lt=%b%b%b%b, required 1001", done8, gt8, eq8, lt8);
        end
    endtask

    task automatic test_mid_reset();
        int ndone;
        @(negedge clk);
        a8 = 8'h00; b8 = 8'h00; sm8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre_busy: got %b, required 1", busy8);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy8, done8, gt8, eq8, lt8} !== 5'b00000) begin
            n_fail++;
            $display("FAIL midrst_async: got busy/done/gt/eq/lt=%b%b%b%b%b, required 00000", busy8, done8, gt8, eq8, lt8);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done8 || busy8) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL midrst_no_done: got %0d active cycles, required 0", ndone);
        end
        // First start after reset is accepted at its first edge.
        a8 = 8'h40; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n_checks++;
        if (busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_accept: got busy=%b, required 1", busy8);
        end
        @(negedge clk);
        n_checks++;
        if ({done8, gt8, eq8, lt8} !== 4'b1100) begin
            n_fail++;
            $display("FAIL post_reset_result: got done/gt/eq/lt=%b%b%b%b, required 1100", done8, gt8, eq8, lt8);
        end
    endtask

    task automatic test_exhaustive();
        int av, bv, ea, eb;
        logic eg, ee, el, to;
        for (int sm = 0; sm < 2; sm++) begin
            for (int v = 0; v < 16; v++) begin
                av = (v >> 2) & 3;
                bv = v & 3;
                ea = (sm == 1 && av >= 2) ? av - 4 : av;
                eb = (sm == 1 && bv >= 2) ? bv - 4 : bv;
                eg = (ea > eb);
                ee = (ea == eb);
                el = (ea < eb);
                @(negedge clk);
                a2 = av[1:0]; b2 = bv[1:0]; sm2 = sm[0]; start2 = 1'b1;
                to = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    start2 = 1'b0;
                    if (done2) begin
                        to = 1'b0;
                        break;
                    end
                end
                n_checks++;
                if (to !== 1'b0 || {gt2, eq2, lt2} !== {eg, ee, el}) begin
                    n_fail++;
                    $display("FAIL sweep sm=%0d a=%0d b=%0d: got gt/eq/lt=%b%b%b timeout=%b, required %b%b%b",
                             sm, av, bv, gt2, eq2, lt2, to, eg, ee, el);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_signed();
        test_back_to_back();
        test_mid_reset();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mag_compare_serial.md
MAG_COMPARE_SERIAL -- requirements
Module: mag_compare_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 2: bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK, and NCH = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a comparison; sampled at the rising edge of clk.
REQ-006 SHALL have port a, input, WIDTH bits: operand A; sampled only when start is accepted.
REQ-007 SHALL have port b, input, WIDTH bits: operand B; sampled only when start is accepted.
REQ-008 SHALL have port signed_mode, input, 1 bit: 1 = two's-complement compare, 0 = unsigned; sampled only when start is accepted.
REQ-009 SHALL have port busy, output, 1 bit: high while in state RUN.
REQ-010 SHALL have port done, output, 1 bit: single-cycle pulse indicating that the results are valid.
REQ-011 SHALL have ports gt, eq and lt, outputs, 1 bit each: registered result of A>B, A==B and A<B.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 Start SHALL be accepted when start=1 at a clock edge while the FSM is in IDLE or DONE.
- On acceptance, a, b and signed_mode are latched and the chunk index is set to NCH-1, which selects the most significant chunk.
- The FSM then moves to RUN.
REQ-014 start SHALL be ignored while in RUN: the latched operands are unchanged and the FSM state is unchanged.
REQ-015 In signed mode, the MSB of both latched operands SHALL be inverted before comparison, so that the compare is performed as an unsigned compare.
REQ-016 In RUN, each cycle SHALL compare the current chunk of A and B as unsigned CHUNK-bit values, working MSB-first.
- If the chunks differ: register gt or lt accordingly, with eq=0, and go to DONE. This is early termination.
- If the chunks are equal and the index is 0: register eq=1, with gt=lt=0, and go to DONE.
- Otherwise: decrement the index and remain in RUN.
REQ-017 Latency SHALL be as follows, where k = NCH minus the index of the first differing chunk, with k=NCH for equal operands:
- The start edge is t.
- The FSM enters DONE at edge t+k.
- done=1 for exactly the cycle following edge t+k.
- The range is therefore 1 to NCH cycles from start to done.
REQ-018 DONE SHALL last one cycle. It then goes to IDLE, unless start=1 at that edge, in which case it goes to RUN (back-to-back operation with no bubble).
REQ-019 gt, eq and lt SHALL be updated only on the transition into DONE. They SHALL hold their values through IDLE and the next RUN until the next DONE.
REQ-020 Exactly one of gt, eq and lt SHALL be 1 after the first completed compare.
REQ-021 busy SHALL be 1 in RUN only. It SHALL be 0 in IDLE and 0 in DONE.
REQ-022 The block SHALL contain no combinational path from the inputs to any output; all outputs SHALL be registered.

Reset
REQ-023 While rst_n=0, asynchronously:
- the FSM is set to IDLE;
- busy=0 and done=0;
- gt=0, eq=0 and lt=0;
- the chunk index and the latched operands are set to 0.
REQ-024 A reset asserted mid-RUN SHALL abort the compare. No done pulse SHALL be produced for the aborted operation.
REQ-025 After rst_n deasserts, the first start SHALL be accepted at the first clock edge on which it is sampled high.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- WIDTH=8, CHUNK=2: a=8'hA5, b=8'h5A, signed_mode=0 -> done 1 cycle after start; gt=1, eq=0, lt=0; busy high for 1 cycle.
- WIDTH=8, CHUNK=2: a=b=8'h3C -> done 4 cycles after start; eq=1, gt=0, lt=0.
- WIDTH=8, CHUNK=2: a=8'h80, b=8'h01 -> with signed_mode=1: lt=1, done after 1 cycle; the same operands with signed_mode=0: gt=1.
- WIDTH=8, CHUNK=2: start with a=8'h11, b=8'h10. While busy, pulse start with a=8'hFF, b=8'h00 -> that pulse is ignored; the result is gt=1 with done after 4 cycles. A start in the DONE cycle is accepted and busy goes high on the next cycle.
- Mid-RUN reset with a=b=8'h00: pull rst_n low 2 cycles after start -> busy=0, done=0 and gt=eq=lt=0 immediately (asynchronously); no done pulse follows.
- WIDTH=2, CHUNK=1: an exhaustive sweep of {a,b}=4'd0..4'd15 in both modes, with one start per completion -> gt, eq and lt match a golden model for all 32 cases.
